// File: rtl/apb_master_arb6.sv
// APB master shared by NUM_REQ6 requesters: round-robin grant, SETUP/ACCESS sequencing, wait states, error and timeout.
// Accept to response is 3 cycles with zero wait states. req_ready6 is offered only while IDLE.
module apb_master_arb6 #(
  parameter int NUM_REQ6     = 4,
  parameter int PADDR_WIDTH6 = 32,
  parameter int PDATA_WIDTH6 = 32,
  parameter int SEL_LSB6     = 28,
  parameter int TIMEOUT6     = 16
) (
  input  logic                             pclock6,
  input  logic                             preset6,
  input  logic [NUM_REQ6-1:0]              req_valid6,
  output logic [NUM_REQ6-1:0]              req_ready6,
  input  logic [NUM_REQ6-1:0]              req_write6,
  input  logic [NUM_REQ6*PADDR_WIDTH6-1:0] req_addr6,
  input  logic [NUM_REQ6*PDATA_WIDTH6-1:0] req_wdata6,
  output logic [NUM_REQ6-1:0]              rsp_valid6,
  output logic [PDATA_WIDTH6-1:0]          rsp_rdata6,
  output logic                             rsp_err6,
  output logic [PADDR_WIDTH6-1:0]          paddr6,
  output logic                             prwd6,
  output logic [PDATA_WIDTH6-1:0]          pwdata6,
  output logic [15:0]                      psel6,
  output logic                             penable6,
  input  logic [PDATA_WIDTH6-1:0]          prdata6,
  input  logic                             pready6,
  input  logic                             pslverr6
);

  localparam int PW = $clog2(NUM_REQ6);
  localparam int CW = $clog2(TIMEOUT6);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, win, gnt;
  logic [PW:0]       sum;
  logic              found;
  logic [CW-1:0]     cnt;
  logic              accept, done_ok, done_to, done;

  logic [PADDR_WIDTH6-1:0] addr_a  [NUM_REQ6];
  logic [PDATA_WIDTH6-1:0] wdata_a [NUM_REQ6];

  for (genvar i = 0; i < NUM_REQ6; i++) begin : g_unpack
    assign addr_a[i]  = req_addr6[i*PADDR_WIDTH6 +: PADDR_WIDTH6];
    assign wdata_a[i] = req_wdata6[i*PDATA_WIDTH6 +: PDATA_WIDTH6];
  end

  // Round-robin search starts just after the last granted requester.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 1; k <= NUM_REQ6; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ6)) sum = sum - (PW+1)'(NUM_REQ6);
      if (!found && req_valid6[sum[PW-1:0]]) begin
        found = 1'b1;
        win   = sum[PW-1:0];
      end
    end
  end

  always_ff @(posedge pclock6) begin
    if (!preset6) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pready6 wins over the timeout when both land in the same cycle.
  always_comb begin
    req_ready6 = '0;
    if (state == IDLE && found) req_ready6[win] = 1'b1;
    accept  = (state == IDLE) && found;
    done_ok = (state == ACCESS) && pready6;
    done_to = (state == ACCESS) && !pready6 && (cnt == CW'(TIMEOUT6-1));
    done    = done_ok || done_to;
  end

  always_ff @(posedge pclock6) begin
    if (!preset6) begin
      ptr        <= PW'(NUM_REQ6-1);
      gnt        <= '0;
      cnt        <= '0;
      paddr6     <= '0;
      pwdata6    <= '0;
      prwd6      <= 1'b0;
      psel6      <= '0;
      penable6   <= 1'b0;
      rsp_valid6 <= '0;
      rsp_rdata6 <= '0;
      rsp_err6   <= 1'b0;
    end else begin
      rsp_valid6 <= '0;
      if (accept) begin
        gnt    <= win;
        ptr    <= win;
        paddr6 <= addr_a[win];
        prwd6  <= req_write6[win];
        if (req_write6[win]) pwdata6 <= wdata_a[win];
        psel6  <= 16'd1 << addr_a[win][SEL_LSB6 +: 4];
      end
      if (state == SETUP) penable6 <= 1'b1;
      if (state == ACCESS) begin
        if (done) begin
          psel6           <= '0;
          penable6        <= 1'b0;
          cnt             <= '0;
          rsp_valid6[gnt] <= 1'b1;
          rsp_rdata6      <= (done_ok && !prwd6) ? prdata6 : '0;
          rsp_err6        <= done_ok ? pslverr6 : 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arb6.sv
// Self-checking bench for apb_master_arb6: directed scenarios plus randomized transfers against a transaction-level model.
module tb_apb_master_arb6;
  localparam int N  = 4;
  localparam int TO = 16;

  logic          pclock6, preset6;
  logic [N-1:0]  req_valid6, req_ready6, req_write6, rsp_valid6;
  logic [N*32-1:0] req_addr6, req_wdata6;
  logic [31:0]   rsp_rdata6, paddr6, pwdata6, prdata6;
  logic          rsp_err6, prwd6, penable6, pready6, pslverr6;
  logic [15:0]   psel6;

  int n_tests = 0;
  int n_fail  = 0;
  int mptr    = N-1;
  logic [31:0] mwdata = '0;

  typedef struct {
    int gnt; int lat; int sel_cyc;
    logic [3:0] rdy; logic [15:0] sel; logic pen0; logic pen1;
    logic [31:0] addr; logic wr; logic [31:0] wdat;
    logic [3:0] rv; logic [31:0] rdat; logic err; logic stable;
  } obs_t;

  apb_master_arb6 dut (
    .pclock6(pclock6), .preset6(preset6),
    .req_valid6(req_valid6), .req_ready6(req_ready6), .req_write6(req_write6),
    .req_addr6(req_addr6), .req_wdata6(req_wdata6),
    .rsp_valid6(rsp_valid6), .rsp_rdata6(rsp_rdata6), .rsp_err6(rsp_err6),
    .paddr6(paddr6), .prwd6(prwd6), .pwdata6(pwdata6), .psel6(psel6), .penable6(penable6),
    .prdata6(prdata6), .pready6(pready6), .pslverr6(pslverr6)
  );

  initial pclock6 = 1'b0;
  always #5 pclock6 = ~pclock6;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge pclock6);
    #1;
  endtask

  // Round-robin rule: first valid requester after the last grant.
  function automatic int rr_pick(input logic [3:0] m, input int last);
    for (int k = 1; k <= N; k++) if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int exp_access(input int waits);
    return (waits >= TO) ? TO : waits + 1;
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    req_write6[i]        = wr;
    req_addr6[i*32 +: 32]  = a;
    req_wdata6[i*32 +: 32] = wd;
  endtask

  // Presents mask, acts as an APB slave with 'waits' not-ready ACCESS cycles, and records what it saw.
  task automatic do_txn(input logic [3:0] mask, input int waits, input logic [31:0] rd,
                        input logic serr, output obs_t o);
    int acc; bit fin; int c;
    o.gnt = -1; o.lat = 0; o.sel_cyc = 0; o.rdy = '0; o.sel = '0; o.pen0 = 1'b0; o.pen1 = 1'b0;
    o.addr = '0; o.wr = 1'b0; o.wdat = '0; o.rv = '0; o.rdat = '0; o.err = 1'b0; o.stable = 1'b1;
    req_valid6 = mask;
    #1;
    c = 0;
    while (req_ready6 == '0 && c < 20) begin tick(); c++; end
    o.rdy = req_ready6;
    for (int i = 0; i < N; i++) if (req_ready6[i]) o.gnt = i;
    if (o.gnt < 0) begin req_valid6 = '0; return; end
    tick();
    req_valid6 = '0;
    o.sel = psel6; o.pen0 = penable6; o.addr = paddr6; o.wr = prwd6; o.wdat = pwdata6;
    acc = 0; fin = 0;
    for (int k = 1; k <= 60 && !fin; k++) begin
      if (k == 2) o.pen1 = penable6;
      if (psel6 != '0) begin
        o.sel_cyc++;
        if (psel6 !== o.sel || paddr6 !== o.addr || prwd6 !== o.wr) o.stable = 1'b0;
      end else if (penable6 !== 1'b0) o.stable = 1'b0;
      if (rsp_valid6 != '0) begin
        o.lat = k; o.rv = rsp_valid6; o.rdat = rsp_rdata6; o.err = rsp_err6; fin = 1;
      end else begin
        if (penable6) begin
          acc++;
          pready6  = (acc > waits);
          prdata6  = pready6 ? rd : $urandom;
          pslverr6 = pready6 & serr;
        end else begin
          pready6 = 1'b0; pslverr6 = 1'b0;
        end
        tick();
      end
    end
    pready6 = 1'b0; pslverr6 = 1'b0;
  endtask

  task automatic test_reset();
    preset6 = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if ({psel6, penable6, prwd6} !== 18'h0) begin n_fail++; $display("FAIL reset_ctrl: psel=%h pen=%b prwd=%b want 0", psel6, penable6, prwd6); end
    n_tests++;
    if ({paddr6, pwdata6} !== 64'h0) begin n_fail++; $display("FAIL reset_data: paddr=%h pwdata=%h want 0", paddr6, pwdata6); end
    n_tests++;
    if ({rsp_valid6, rsp_rdata6, rsp_err6} !== 37'h0 || req_ready6 !== 4'h0) begin
      n_fail++; $display("FAIL reset_rsp: rv=%h rd=%h err=%b rdy=%h want 0", rsp_valid6, rsp_rdata6, rsp_err6, req_ready6);
    end
    preset6 = 1'b1;
    mptr = N-1; mwdata = '0;
    tick();
  endtask

  task automatic test_single_write();
    obs_t o;
    set_req(0, 1'b1, 32'h2000_0010, 32'hDEAD_BEEF);
    do_txn(4'b0001, 0, 32'h0, 1'b0, o);
    mptr = 0; mwdata = 32'hDEAD_BEEF;
    n_tests++;
    if (o.rdy !== 4'b0001) begin n_fail++; $display("FAIL wr_ready: got %b want 0001", o.rdy); end
    n_tests++;
    if (o.sel !== 16'h0004 || o.pen0 !== 1'b0 || o.pen1 !== 1'b1) begin
      n_fail++; $display("FAIL wr_setup: psel=%h pen@T+1=%b pen@T+2=%b want 0004/0/1", o.sel, o.pen0, o.pen1);
    end
    n_tests++;
    if (o.addr !== 32'h2000_0010 || o.wr !== 1'b1 || o.wdat !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wr_bus: paddr=%h prwd=%b pwdata=%h", o.addr, o.wr, o.wdat);
    end
    n_tests++;
    if (o.lat !== 3 || o.rv !== 4'b0001 || o.err !== 1'b0 || o.rdat !== 32'h0) begin
      n_fail++; $display("FAIL wr_rsp: lat=%0d rv=%b err=%b rd=%h want 3/0001/0/0", o.lat, o.rv, o.err, o.rdat);
    end
    tick();
    n_tests++;
    if (rsp_valid6 !== 4'b0000) begin n_fail++; $display("FAIL wr_pulse: rv=%b want 0000 one cycle later", rsp_valid6); end
  endtask

  task automatic test_read_waits();
    obs_t o;
    set_req(2, 1'b0, 32'hF000_0004, 32'h5555_AAAA);
    do_txn(4'b0100, 3, 32'h1234_5678, 1'b0, o);
    mptr = 2;
    n_tests++;
    if (o.sel !== 16'h8000 || o.sel_cyc !== 5 || !o.stable) begin
      n_fail++; $display("FAIL rd_sel: psel=%h cycles=%0d stable=%b want 8000/5/1", o.sel, o.sel_cyc, o.stable);
    end
    n_tests++;
    if (o.wdat !== mwdata || o.wr !== 1'b0) begin n_fail++; $display("FAIL rd_pwdata_hold: pwdata=%h want %h", o.wdat, mwdata); end
    n_tests++;
    if (o.rv !== 4'b0100 || o.rdat !== 32'h1234_5678 || o.err !== 1'b0 || o.lat !== 6) begin
      n_fail++; $display("FAIL rd_rsp: rv=%b rd=%h err=%b lat=%0d want 0100/12345678/0/6", o.rv, o.rdat, o.err, o.lat);
    end
  endtask

  task automatic test_round_robin();
    int grants; int e;
    req_valid6 = '0;
    preset6 = 1'b0; tick(); tick();
    mptr = N-1; mwdata = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h1000_0000 * i, 32'hA000_0000 + i);
    pready6 = 1'b1;
    preset6 = 1'b1;
    req_valid6 = '1;
    #1;
    grants = 0;
    for (int c = 0; c < 40 && grants < 5; c++) begin
      if (req_ready6 != '0) begin
        e = rr_pick(4'hF, mptr);
        n_tests++;
        if (req_ready6 !== (4'b0001 << e)) begin n_fail++; $display("FAIL rr_grant%0d: rdy=%b want %b", grants, req_ready6, 4'b0001 << e); end
        mptr = e; mwdata = 32'hA000_0000 + e;
        grants++;
      end
      tick();
    end
    req_valid6 = '0;
    n_tests++;
    if (grants !== 5) begin n_fail++; $display("FAIL rr_count: grants=%0d want 5", grants); end
    tick(); tick(); tick();
    pready6 = 1'b0;
  endtask

  task automatic test_slave_error();
    obs_t o;
    set_req(1, 1'b1, 32'h5000_0100, 32'hCAFE_0001);
    do_txn(4'b0010, 1, 32'h0, 1'b1, o);
    mptr = 1; mwdata = 32'hCAFE_0001;
    n_tests++;
    if (o.rv !== 4'b0010 || o.err !== 1'b1 || o.lat !== 4) begin
      n_fail++; $display("FAIL err_rsp: rv=%b err=%b lat=%0d want 0010/1/4", o.rv, o.err, o.lat);
    end
    set_req(3, 1'b0, 32'h6000_0200, 32'h0);
    do_txn(4'b1000, 0, 32'h0BAD_F00D, 1'b0, o);
    mptr = 3;
    n_tests++;
    if (o.gnt !== 3 || o.err !== 1'b0 || o.rdat !== 32'h0BAD_F00D || o.sel !== 16'h0040) begin
      n_fail++; $display("FAIL err_next: gnt=%0d err=%b rd=%h psel=%h want 3/0/0badf00d/0040", o.gnt, o.err, o.rdat, o.sel);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    set_req(2, 1'b0, 32'h9000_0000, 32'h0);
    do_txn(4'b0100, 1000, 32'hFFFF_FFFF, 1'b0, o);
    mptr = 2;
    n_tests++;
    if (o.sel_cyc !== 1 + TO || o.lat !== TO + 2) begin
      n_fail++; $display("FAIL to_len: psel cycles=%0d lat=%0d want %0d/%0d", o.sel_cyc, o.lat, 1 + TO, TO + 2);
    end
    n_tests++;
    if (o.err !== 1'b1 || o.rdat !== 32'h0 || o.rv !== 4'b0100) begin
      n_fail++; $display("FAIL to_rsp: err=%b rd=%h rv=%b want 1/0/0100", o.err, o.rdat, o.rv);
    end
    pready6 = 1'b1; prdata6 = 32'h7777_7777;
    tick(); tick();
    n_tests++;
    if (rsp_valid6 !== 4'b0 || psel6 !== 16'h0 || rsp_rdata6 !== 32'h0 || rsp_err6 !== 1'b1) begin
      n_fail++; $display("FAIL to_late_ready: rv=%b psel=%h rd=%h err=%b", rsp_valid6, psel6, rsp_rdata6, rsp_err6);
    end
    pready6 = 1'b0;
  endtask

  task automatic test_reset_mid_transfer();
    obs_t o; logic [3:0] seen;
    set_req(0, 1'b0, 32'h3000_0000, 32'h0);
    req_valid6 = 4'b0001;
    #1;
    tick();
    req_valid6 = '0;
    pready6 = 1'b0;
    tick(); tick();
    preset6 = 1'b0;
    tick();
    n_tests++;
    if (psel6 !== 16'h0 || penable6 !== 1'b0 || rsp_valid6 !== 4'b0) begin
      n_fail++; $display("FAIL rst_mid: psel=%h pen=%b rv=%b want 0", psel6, penable6, rsp_valid6);
    end
    preset6 = 1'b1;
    mptr = N-1; mwdata = '0;
    seen = '0;
    for (int c = 0; c < 4; c++) begin tick(); seen |= rsp_valid6; end
    n_tests++;
    if (seen !== 4'b0) begin n_fail++; $display("FAIL rst_no_rsp: rv seen=%b want 0000", seen); end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h4000_0000 + 4*i, 32'h0);
    do_txn(4'hF, 0, 32'h1111_2222, 1'b0, o);
    mptr = 0;
    n_tests++;
    if (o.gnt !== 0 || o.rv !== 4'b0001) begin n_fail++; $display("FAIL rst_first: gnt=%0d rv=%b want 0/0001", o.gnt, o.rv); end
  endtask

  task automatic test_random();
    obs_t o; logic [3:0] mask; int waits; int g; logic serr;
    logic [31:0] a [N]; logic [31:0] w [N]; logic wr [N]; logic [31:0] rd;
    logic [31:0] exp_rd; logic exp_err;
    for (int it = 0; it < 40; it++) begin
      mask  = 4'($urandom_range(1, 15));
      waits = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
      serr  = ($urandom_range(0, 3) == 0);
      rd    = $urandom;
      for (int i = 0; i < N; i++) begin
        a[i] = $urandom; w[i] = $urandom; wr[i] = 1'($urandom_range(0, 1));
        set_req(i, wr[i], a[i], w[i]);
      end
      g = rr_pick(mask, mptr);
      do_txn(mask, waits, rd, serr, o);
      n_tests++;
      if (o.gnt !== g) begin n_fail++; $display("FAIL rnd%0d_grant: gnt=%0d want %0d", it, o.gnt, g); end
      if (o.gnt < 0) continue;
      mptr = g;
      if (wr[g]) mwdata = w[g];
      n_tests++;
      if (o.sel !== (16'h1 << a[g][31:28]) || o.addr !== a[g] || o.wr !== wr[g] || o.wdat !== mwdata || !o.stable) begin
        n_fail++; $display("FAIL rnd%0d_bus: psel=%h paddr=%h prwd=%b pwdata=%h stable=%b want %h/%h/%b/%h/1",
                           it, o.sel, o.addr, o.wr, o.wdat, o.stable, 16'h1 << a[g][31:28], a[g], wr[g], mwdata);
      end
      exp_err = (waits >= TO) ? 1'b1 : serr;
      exp_rd  = (waits >= TO || wr[g]) ? 32'h0 : rd;
      n_tests++;
      if (o.lat !== exp_access(waits) + 2 || o.rv !== (4'b0001 << g) || o.rdat !== exp_rd || o.err !== exp_err) begin
        n_fail++; $display("FAIL rnd%0d_rsp: lat=%0d rv=%b rd=%h err=%b want %0d/%b/%h/%b",
                           it, o.lat, o.rv, o.rdat, o.err, exp_access(waits) + 2, 4'b0001 << g, exp_rd, exp_err);
      end
    end
  endtask

  initial begin
    preset6 = 1'b0; req_valid6 = '0; req_write6 = '0; req_addr6 = '0; req_wdata6 = '0;
    prdata6 = '0; pready6 = 1'b0; pslverr6 = 1'b0;
    test_reset();
    test_single_write();
    test_read_waits();
    test_round_robin();
    test_slave_error();
    test_timeout();
    test_reset_mid_transfer();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
